// File: rtl/ucsbece154b_issue_scoreboard.sv
// In-order issue controller: per-register pending-write scoreboard decides which prefix of the
// decoded bundle may issue. Optional statistics counters are enabled with `define ISSUE_STATS_EN.
module ucsbece154b_issue_scoreboard #(
  parameter int SLOTS    = 2,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLOTS-1:0]   valid_i,
  input  logic [5*SLOTS-1:0] rs1_i,
  input  logic [5*SLOTS-1:0] rs2_i,
  input  logic [SLOTS-1:0]   rs1used_i,
  input  logic [SLOTS-1:0]   rs2used_i,
  input  logic [5*SLOTS-1:0] rd_i,
  input  logic [SLOTS-1:0]   regwrite_i,
  input  logic [SLOTS-1:0]   load_i,
  input  logic [SLOTS-1:0]   ctrl_i,
  input  logic               hold_i,
  input  logic               flush_i,
`ifdef ISSUE_STATS_EN
  output logic [31:0]        stat_cycles_o,
  output logic [31:0]        stat_issued_o,
  output logic [31:0]        stat_stall_o,
`endif
  output logic [SLOTS-1:0]   issue_o,
  output logic               stallD_o,
  output logic [31:0]        busy_o
);

  localparam int MAXLAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW     = (MAXLAT == 0) ? 1 : $clog2(MAXLAT + 1);
  localparam logic [CW-1:0] ALU_V  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_V = CW'(LOAD_LAT);

  logic [CW-1:0]    cnt_q [32];
  logic [CW-1:0]    cnt_d [32];
  logic [31:0]      busy;
  logic [31:0]      wr_mask;
  logic [SLOTS-1:0] issue;
  logic             chain;
  logic             ok;

  always_comb begin
    for (int r = 0; r < 32; r++) busy[r] = (cnt_q[r] != '0);
  end

  // Walk the bundle oldest-first; any blocked slot breaks the chain for all younger slots.
  always_comb begin
    issue   = '0;
    wr_mask = '0;
    ok      = 1'b0;
    chain   = reset && !hold_i && !flush_i;
    for (int k = 0; k < SLOTS; k++) begin
      ok = chain && valid_i[k];
      if (rs1used_i[k] && (rs1_i[5*k +: 5] != 5'd0) &&
          (busy[rs1_i[5*k +: 5]] || wr_mask[rs1_i[5*k +: 5]]))
        ok = 1'b0;
      if (rs2used_i[k] && (rs2_i[5*k +: 5] != 5'd0) &&
          (busy[rs2_i[5*k +: 5]] || wr_mask[rs2_i[5*k +: 5]]))
        ok = 1'b0;
      if (regwrite_i[k] && (rd_i[5*k +: 5] != 5'd0) && wr_mask[rd_i[5*k +: 5]])
        ok = 1'b0;
      issue[k] = ok;
      if (ok && regwrite_i[k] && (rd_i[5*k +: 5] != 5'd0))
        wr_mask[rd_i[5*k +: 5]] = 1'b1;
      chain = ok && !ctrl_i[k];
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];
    // A fresh issue overrides the decrement of the same register.
    for (int k = 0; k < SLOTS; k++) begin
      if (issue[k] && regwrite_i[k] && (rd_i[5*k +: 5] != 5'd0))
        cnt_d[rd_i[5*k +: 5]] = load_i[k] ? LOAD_V : ALU_V;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else if (!hold_i) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign issue_o  = issue;
  assign stallD_o = reset && (|(valid_i & ~issue));
  assign busy_o   = reset ? busy : 32'd0;

`ifdef ISSUE_STATS_EN
  logic [31:0] cycles_q, issued_q, stall_q;
  logic [31:0] pop;

  always_comb begin
    pop = 32'd0;
    for (int k = 0; k < SLOTS; k++) pop = pop + 32'(issue[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q <= 32'd0;
      issued_q <= 32'd0;
      stall_q  <= 32'd0;
    end else if (!hold_i) begin
      cycles_q <= cycles_q + 32'd1;
      issued_q <= issued_q + pop;
      stall_q  <= stall_q + 32'(stallD_o);
    end
  end

  assign stat_cycles_o = cycles_q;
  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_issue_scoreboard.sv
// Directed vector bench for the issue scoreboard (SLOTS=2, ALU_LAT=0, LOAD_LAT=1).
module tb_ucsbece154b_issue_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, ld, ct;
  } ins_t;

  typedef struct packed {
    ins_t        s0, s1;
    logic        hold, flush;
    logic [1:0]  exp_issue;
    logic        exp_stall;
    logic [31:0] exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  valid_i = '0, rs1used_i = '0, rs2used_i = '0, regwrite_i = '0, load_i = '0, ctrl_i = '0;
  logic [9:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic        hold_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  issue_o;
  logic        stallD_o;
  logic [31:0] busy_o;
`ifdef ISSUE_STATS_EN
  logic [31:0] stat_cycles_o, stat_issued_o, stat_stall_o;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  ucsbece154b_issue_scoreboard #(.SLOTS(2), .ALU_LAT(0), .LOAD_LAT(1)) dut (
    .clk(clk), .reset(rst_n),
    .valid_i(valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1used_i(rs1used_i), .rs2used_i(rs2used_i),
    .rd_i(rd_i), .regwrite_i(regwrite_i), .load_i(load_i), .ctrl_i(ctrl_i),
    .hold_i(hold_i), .flush_i(flush_i),
`ifdef ISSUE_STATS_EN
    .stat_cycles_o(stat_cycles_o), .stat_issued_o(stat_issued_o), .stat_stall_o(stat_stall_o),
`endif
    .issue_o(issue_o), .stallD_o(stallD_o), .busy_o(busy_o)
  );

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t alu(int rd, int a, int b, bit u2 = 1'b1);
    ins_t i = '0;
    i.v = 1; i.rd = 5'(rd); i.rs1 = 5'(a); i.rs2 = 5'(b); i.u1 = 1; i.u2 = u2; i.rw = 1;
    return i;
  endfunction
  function automatic ins_t alui(int rd, int a);
    ins_t i = alu(rd, a, 0, 1'b0);
    return i;
  endfunction
  function automatic ins_t lw(int rd, int a);
    ins_t i = alui(rd, a);
    i.ld = 1;
    return i;
  endfunction
  function automatic ins_t br(int a, int b);
    ins_t i = '0;
    i.v = 1; i.rs1 = 5'(a); i.rs2 = 5'(b); i.u1 = 1; i.u2 = 1; i.ct = 1;
    return i;
  endfunction
  function automatic vec_t mk(ins_t s0, ins_t s1, bit hold, bit flush,
                              logic [1:0] ei, bit es, logic [31:0] eb);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.hold = hold; v.flush = flush;
    v.exp_issue = ei; v.exp_stall = es; v.exp_busy = eb;
    return v;
  endfunction

  task automatic drive(ins_t s0, ins_t s1, bit hold, bit flush);
    valid_i    = {s1.v, s0.v};
    rs1_i      = {s1.rs1, s0.rs1};
    rs2_i      = {s1.rs2, s0.rs2};
    rd_i       = {s1.rd, s0.rd};
    rs1used_i  = {s1.u1, s0.u1};
    rs2used_i  = {s1.u2, s0.u2};
    regwrite_i = {s1.rw, s0.rw};
    load_i     = {s1.ld, s0.ld};
    ctrl_i     = {s1.ct, s0.ct};
    hold_i     = hold;
    flush_i    = flush;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] B5 = 32'h1 << 5;
  localparam logic [31:0] B8 = 32'h1 << 8;

  initial begin
    vt.push_back(mk(lw(5,1),       alu(6,5,1),   0, 0, 2'b01, 1, 0));   // load-use in bundle
    vt.push_back(mk(alu(6,5,1),    nop(),        0, 0, 2'b00, 1, B5));
    vt.push_back(mk(alu(6,5,1),    nop(),        0, 0, 2'b01, 0, 0));
    vt.push_back(mk(alui(7,1),     alui(7,2),    0, 0, 2'b01, 1, 0));   // WAW
    vt.push_back(mk(br(1,2),       alu(3,1,2),   0, 0, 2'b01, 1, 0));   // control closes bundle
    vt.push_back(mk(alui(0,1),     alu(3,0,0),   0, 0, 2'b11, 0, 0));   // x0 never hazards
    vt.push_back(mk(lw(5,1),       nop(),        0, 0, 2'b01, 0, 0));
    vt.push_back(mk(alu(2,0,5,0),  nop(),        0, 0, 2'b01, 0, B5));  // unused rs2 on busy reg
    vt.push_back(mk(nop(),         nop(),        0, 0, 2'b00, 0, 0));
    vt.push_back(mk(alu(4,1,2),    alu(6,3,4),   0, 0, 2'b01, 1, 0));   // rs2 RAW
    vt.push_back(mk(lw(9,1),       nop(),        0, 1, 2'b00, 1, 0));   // flush
    vt.push_back(mk(lw(5,1),       nop(),        0, 0, 2'b01, 0, 0));
    vt.push_back(mk(alu(6,5,1),    nop(),        1, 0, 2'b00, 1, B5));  // hold x3
    vt.push_back(mk(alu(6,5,1),    nop(),        1, 0, 2'b00, 1, B5));
    vt.push_back(mk(alu(6,5,1),    nop(),        1, 0, 2'b00, 1, B5));
    vt.push_back(mk(alu(6,5,1),    nop(),        0, 0, 2'b00, 1, B5));  // frozen count resumes
    vt.push_back(mk(alu(6,5,1),    nop(),        0, 0, 2'b01, 0, 0));
    vt.push_back(mk(alu(5,1,2),    alu(1,3,4),   0, 0, 2'b11, 0, 0));   // WAR allowed
    vt.push_back(mk(lw(8,1),       alu(9,8,8),   0, 0, 2'b01, 1, 0));
    vt.push_back(mk(alu(10,1,8),   nop(),        0, 0, 2'b00, 1, B8));
    vt.push_back(mk(nop(),         alu(3,1,2),   0, 0, 2'b00, 1, 0));   // prefix only
    vt.push_back(mk(alu(4,1,2),    alu(6,1,4,0), 0, 0, 2'b11, 0, 0));   // RAW on unused rs2

    // Outputs forced low while reset is held, even with valid slots.
    drive(alu(1,2,3), alu(4,2,3), 0, 0);
    #2;
    chk("rst_issue", 32'(issue_o), 0);
    chk("rst_stall", 32'(stallD_o), 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].s0, vt[i].s1, vt[i].hold, vt[i].flush);
      #2;
      chk($sformatf("v%0d_issue", i), 32'(issue_o), 32'(vt[i].exp_issue));
      chk($sformatf("v%0d_stall", i), 32'(stallD_o), 32'(vt[i].exp_stall));
      chk($sformatf("v%0d_busy", i), busy_o, vt[i].exp_busy);
      @(negedge clk);
    end

    // Mid-cycle reset clears a live counter at once.
    drive(lw(5,1), nop(), 0, 0);
    @(negedge clk);
    drive(alu(6,5,1), nop(), 0, 0);
    #2;
    chk("pre_rst_busy", busy_o, B5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_issue", 32'(issue_o), 0);
    chk("mid_rst_stall", 32'(stallD_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_issue", 32'(issue_o), 32'b01);

`ifdef ISSUE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(alu(10,1,2), alu(11,1,2), 0, 0);
    for (int c = 0; c < 10; c++) @(negedge clk);
    #2;
    chk("stat_issued", stat_issued_o, 32'd20);
    chk("stat_cycles", stat_cycles_o, 32'd10);
    chk("stat_stall", stat_stall_o, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("stat_rst_issued", stat_issued_o, 0);
    chk("stat_rst_cycles", stat_cycles_o, 0);
    chk("stat_rst_stall", stat_stall_o, 0);
    chk("stat_rst_issue", 32'(issue_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
